// File: rtl/scs8hd_togmon_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_togmon_pkg
// Shared types and helpers for the scs8hd_toggle_mon activity monitor.
//   togmon_state_e : readout/counting FSM states (IDLE, RUN, SNAP, WAIT)
//   GLITCH_W       : width of the optional glitch counter
//   filt_cnt_w()   : width of the stability-filter counter for a FILT_CYC value
// -----------------------------------------------------------------------------
package scs8hd_togmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SNAP = 2'd2,
    WAIT = 2'd3
  } togmon_state_e;

  localparam int GLITCH_W = 8;

  // The filter counter must represent 0..FILT_CYC.
  function automatic int filt_cnt_w(input int filt_cyc);
    return $clog2(filt_cyc + 1);
  endfunction

endpackage

// File: rtl/scs8hd_togmon_sync.sv
// -----------------------------------------------------------------------------
// scs8hd_togmon_sync
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input level
//   q     : synchronized level (STAGES flops after d)
// Parameters:
//   STAGES : number of flops in the chain (2..4)
// -----------------------------------------------------------------------------
module scs8hd_togmon_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value, giving a true shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/scs8hd_toggle_mon.sv
// -----------------------------------------------------------------------------
// scs8hd_toggle_mon
// Clocked activity monitor for a combinational cell output. Y_IN is
// synchronized, deglitched by a stability filter, and accepted rising/falling
// transitions are counted in saturating counters. A 4-phase RD_REQ/RD_ACK
// handshake exposes a coherent snapshot of both counts.
//
// Ports:
//   CLK        : sole clock, rising edge
//   RESETB     : asynchronous active-low reset
//   Y_IN       : monitored cell output (asynchronous)
//   EN         : counting enable
//   CLR        : synchronous clear of live counters and SAT
//   RD_REQ     : readout request (level)
//   RD_ACK     : snapshot valid / acknowledge
//   LEVEL      : filtered, accepted level of Y_IN
//   RISE_CNT   : snapshot of the rising-transition count
//   FALL_CNT   : snapshot of the falling-transition count
//   SAT        : sticky, a live counter saturated since the last CLR
//   GLITCH_CNT : snapshot of rejected-pulse count (only with the macro below)
//
// Build option: define SCS8HD_TOGMON_GLITCH_EN to add the glitch counter.
// -----------------------------------------------------------------------------
module scs8hd_toggle_mon
  import scs8hd_togmon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 2
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             Y_IN,
  input  logic             EN,
  input  logic             CLR,
  input  logic             RD_REQ,
  output logic             RD_ACK,
  output logic             LEVEL,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic             SAT
`ifdef SCS8HD_TOGMON_GLITCH_EN
  ,
  output logic [GLITCH_W-1:0] GLITCH_CNT
`endif
);

  localparam int FC_W = filt_cnt_w(FILT_CYC);

  togmon_state_e    state;
  logic             s;
  logic [FC_W-1:0]  fc;
  logic             differ;
  logic             accept;
  logic             rise_evt;
  logic             fall_evt;
  logic             count_ok;
  logic [CNT_W-1:0] rise_live;
  logic [CNT_W-1:0] fall_live;

  scs8hd_togmon_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RESETB),
    .d    (Y_IN),
    .q    (s)
  );

  // Stability filter: a new level must be seen on FILT_CYC consecutive
  // edges; the last of those edges updates LEVEL.
  assign differ   = (s != LEVEL);
  assign accept   = differ && (fc == FC_W'(FILT_CYC - 1));
  assign rise_evt = accept &&  s;
  assign fall_evt = accept && !s;
  // The filter keeps running in IDLE so LEVEL is current on re-enable;
  // only the counting is gated.
  assign count_ok = (state != IDLE);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      fc    <= '0;
      LEVEL <= 1'b0;
    end else if (accept) begin
      fc    <= '0;
      LEVEL <= s;
    end else if (differ) begin
      fc    <= fc + 1'b1;
    end else begin
      fc    <= '0;
    end
  end

  // Live counters: CLR wins over an increment on the same edge. A counter
  // at all-ones holds and raises SAT instead of wrapping.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rise_live <= '0;
      fall_live <= '0;
      SAT       <= 1'b0;
    end else if (CLR) begin
      rise_live <= '0;
      fall_live <= '0;
      SAT       <= 1'b0;
    end else if (count_ok) begin
      if (rise_evt) begin
        if (&rise_live) SAT       <= 1'b1;
        else            rise_live <= rise_live + 1'b1;
      end
      if (fall_evt) begin
        if (&fall_live) SAT       <= 1'b1;
        else            fall_live <= fall_live + 1'b1;
      end
    end
  end

`ifdef SCS8HD_TOGMON_GLITCH_EN
  logic [GLITCH_W-1:0] glitch_live;
  logic                glitch_evt;

  // A run of differing samples that ends before acceptance is a glitch.
  assign glitch_evt = (fc != '0) && !differ;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB)                                 glitch_live <= '0;
    else if (CLR)                                glitch_live <= '0;
    else if (count_ok && glitch_evt && !(&glitch_live)) glitch_live <= glitch_live + 1'b1;
  end
`endif

  // Readout FSM. SNAP captures the live counters as they were before this
  // edge, so an increment or CLR landing on the same edge is excluded.
  // NOTE: the snapshot registers are reset too, so RISE_CNT/FALL_CNT read a
  // defined 0 before the first readout rather than power-up garbage.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= IDLE;
      RD_ACK     <= 1'b0;
      RISE_CNT   <= '0;
      FALL_CNT   <= '0;
`ifdef SCS8HD_TOGMON_GLITCH_EN
      GLITCH_CNT <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (EN) state <= RUN;
        RUN: begin
          if (RD_REQ)   state <= SNAP;
          else if (!EN) state <= IDLE;
        end
        SNAP: begin
          RISE_CNT   <= rise_live;
          FALL_CNT   <= fall_live;
`ifdef SCS8HD_TOGMON_GLITCH_EN
          GLITCH_CNT <= glitch_live;
`endif
          RD_ACK     <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (!RD_REQ) begin
            RD_ACK <= 1'b0;
            state  <= EN ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scs8hd_toggle_mon.sv
// -----------------------------------------------------------------------------
// tb_scs8hd_toggle_mon
// Two monitors share all inputs: one with default parameters and one with
// CNT_W=4 for saturation. A reference model, evaluated on every clock edge
// from the bench's own input values, predicts LEVEL, the handshake and the
// snapshot contents using queues of samples and unbounded counts.
// -----------------------------------------------------------------------------
module tb_scs8hd_toggle_mon;

  localparam int S = 2;
  localparam int F = 2;

  logic CLK    = 1'b0;
  logic RESETB = 1'b0;
  logic Y_IN   = 1'b0;
  logic EN     = 1'b0;
  logic CLR    = 1'b0;
  logic RD_REQ = 1'b0;

  logic        rd_ack, level, sat;
  logic [15:0] rise_cnt, fall_cnt;
  logic        rd_ack4, level4, sat4;
  logic [3:0]  rise_cnt4, fall_cnt4;
`ifdef SCS8HD_TOGMON_GLITCH_EN
  logic [7:0]  glitch_cnt, glitch_cnt4;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  scs8hd_toggle_mon dut (
    .CLK(CLK), .RESETB(RESETB), .Y_IN(Y_IN), .EN(EN), .CLR(CLR),
    .RD_REQ(RD_REQ), .RD_ACK(rd_ack), .LEVEL(level),
    .RISE_CNT(rise_cnt), .FALL_CNT(fall_cnt), .SAT(sat)
`ifdef SCS8HD_TOGMON_GLITCH_EN
    , .GLITCH_CNT(glitch_cnt)
`endif
  );

  scs8hd_toggle_mon #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RESETB(RESETB), .Y_IN(Y_IN), .EN(EN), .CLR(CLR),
    .RD_REQ(RD_REQ), .RD_ACK(rd_ack4), .LEVEL(level4),
    .RISE_CNT(rise_cnt4), .FALL_CNT(fall_cnt4), .SAT(sat4)
`ifdef SCS8HD_TOGMON_GLITCH_EN
    , .GLITCH_CNT(glitch_cnt4)
`endif
  );

  // ---------------------------------------------------------------- model
  typedef enum {M_IDLE, M_RUN, M_SNAP, M_WAIT} m_state_e;
  m_state_e m_state = M_IDLE;
  bit m_pipe[$];        // Y_IN samples still travelling through the synchronizer
  bit m_hist[$];        // the last F synchronized samples
  bit m_lvl  = 1'b0;
  bit m_pend = 1'b0;    // a differing run is in progress and not yet accepted
  bit m_ack  = 1'b0;
  int m_rise = 0, m_fall = 0, m_glit = 0;       // attempts since last CLR
  int m_snap_r = 0, m_snap_f = 0, m_snap_g = 0;

  always @(posedge CLK or negedge RESETB) begin : model
    bit s, acc, gl, act;
    if (!RESETB) begin
      m_pipe.delete();
      for (int i = 0; i < S; i++) m_pipe.push_back(1'b0);
      m_hist.delete();
      m_lvl = 0; m_pend = 0; m_ack = 0; m_state = M_IDLE;
      m_rise = 0; m_fall = 0; m_glit = 0;
      m_snap_r = 0; m_snap_f = 0; m_snap_g = 0;
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(Y_IN);
      m_hist.push_back(s);
      if (m_hist.size() > F) void'(m_hist.pop_front());
      acc = (m_hist.size() == F);
      foreach (m_hist[i]) if (m_hist[i] == m_lvl) acc = 1'b0;
      gl  = m_pend && (s == m_lvl);
      act = (m_state != M_IDLE);
      if (m_state == M_SNAP) begin
        m_snap_r = m_rise; m_snap_f = m_fall; m_snap_g = m_glit;
      end
      if (CLR) begin
        m_rise = 0; m_fall = 0; m_glit = 0;
      end else if (act) begin
        if (acc &&  s) m_rise++;
        if (acc && !s) m_fall++;
        if (gl)        m_glit++;
      end
      m_pend = (s != m_lvl) && !acc;
      if (acc) m_lvl = s;
      case (m_state)
        M_IDLE: if (EN) m_state = M_RUN;
        M_RUN:  if (RD_REQ) m_state = M_SNAP; else if (!EN) m_state = M_IDLE;
        M_SNAP: begin m_state = M_WAIT; m_ack = 1'b1; end
        M_WAIT: if (!RD_REQ) begin m_ack = 1'b0; m_state = EN ? M_RUN : M_IDLE; end
      endcase
    end
  end

  function automatic int cap(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [32:0] exp_snap16();
    return {16'(cap(m_snap_r, 16)), 16'(cap(m_snap_f, 16)),
            (m_rise > 65535) || (m_fall > 65535)};
  endfunction

  function automatic logic [8:0] exp_snap4();
    return {4'(cap(m_snap_r, 4)), 4'(cap(m_snap_f, 4)), (m_rise > 15) || (m_fall > 15)};
  endfunction

  // ------------------------------------------------------------ stimulus
  task automatic pulse(input int hi, input int lo);
    Y_IN = 1'b1;
    repeat (hi) @(negedge CLK);
    Y_IN = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic clear_live();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  // Raise the request and wait (bounded) for both acknowledges.
  task automatic do_read();
    int n = 0;
    EN = 1'b1;
    RD_REQ = 1'b1;
    while ({rd_ack, rd_ack4} !== 2'b11 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if ({rd_ack, rd_ack4} !== 2'b11) begin
      errors++;
      $display("FAIL read_ack_timeout: RD_ACK=%b/%b want 1/1", rd_ack, rd_ack4);
    end
  endtask

  // Drop the request; the acknowledge must fall on the very next edge.
  task automatic end_read();
    int n = 0;
    RD_REQ = 1'b0;
    do begin
      @(negedge CLK);
      n++;
    end while ({rd_ack, rd_ack4} !== 2'b00 && n < 20);
    tests++;
    if ({rd_ack, rd_ack4} !== 2'b00 || n != 1) begin
      errors++;
      $display("FAIL ack_release: RD_ACK=%b/%b after %0d edges want 00 after 1",
               rd_ack, rd_ack4, n);
    end
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    tests++;
    if ({rd_ack, level, rise_cnt, fall_cnt, sat, rd_ack4, level4, rise_cnt4, fall_cnt4, sat4} !== '0) begin
      errors++;
      $display("FAIL reset_state: ack=%b lvl=%b rise=%h fall=%h sat=%b want all 0",
               rd_ack, level, rise_cnt, fall_cnt, sat);
    end
    RESETB = 1'b1;
    EN = 1'b1;
    Y_IN = 1'b1;
    repeat (6) @(negedge CLK);
    do_read();
    tests++;
    if ({rise_cnt, fall_cnt, level} !== {16'd1, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_snap: rise=%0d fall=%0d lvl=%b want 1 0 1", rise_cnt, fall_cnt, level);
    end
    // Asynchronous reset in the middle of WAIT, away from any clock edge.
    #2 RESETB = 1'b0;
    RD_REQ = 1'b0;
    #1;
    tests++;
    if ({rd_ack, level, rise_cnt, fall_cnt, sat, rd_ack4, level4, rise_cnt4, fall_cnt4, sat4} !== '0) begin
      errors++;
      $display("FAIL async_reset: ack=%b lvl=%b rise=%h fall=%h sat=%b want all 0",
               rd_ack, level, rise_cnt, fall_cnt, sat);
    end
    @(negedge CLK);
    RESETB = 1'b1;
    // Y_IN held at 1: edge 1 samples it, LEVEL must rise on edge 4.
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      tests++;
      if (level !== (i == 4) || level4 !== (i == 4)) begin
        errors++;
        $display("FAIL reset_latency edge %0d: LEVEL=%b want %b", i, level, (i == 4));
      end
    end
  endtask

  task automatic test_counting();
    Y_IN = 1'b0;
    repeat (6) @(negedge CLK);
    clear_live();
    for (int i = 0; i < 5; i++) pulse(6, 6);
    do_read();
    tests++;
    if ({rise_cnt, fall_cnt, sat} !== {16'd5, 16'd5, 1'b0} || {rise_cnt, fall_cnt, sat} !== exp_snap16()) begin
      errors++;
      $display("FAIL count_5: got %0d/%0d sat=%b want 5/5 sat=0", rise_cnt, fall_cnt, sat);
    end
    tests++;
    if ({rise_cnt4, fall_cnt4, sat4} !== {4'd5, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL count_5_w4: got %0d/%0d sat=%b want 5/5 sat=0", rise_cnt4, fall_cnt4, sat4);
    end
    end_read();
  endtask

  task automatic test_glitch();
    bit seen_hi = 1'b0;
    Y_IN = 1'b1;
    @(negedge CLK);
    Y_IN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (level || level4) seen_hi = 1'b1;
    end
    tests++;
    if (seen_hi) begin
      errors++;
      $display("FAIL glitch_level: LEVEL went high want stay 0");
    end
    do_read();
    tests++;
    if ({rise_cnt, fall_cnt} !== {16'd5, 16'd5} || {rise_cnt, fall_cnt, sat} !== exp_snap16()) begin
      errors++;
      $display("FAIL glitch_counts: got %0d/%0d want 5/5", rise_cnt, fall_cnt);
    end
`ifdef SCS8HD_TOGMON_GLITCH_EN
    tests++;
    if (glitch_cnt !== 8'd1 || glitch_cnt4 !== 8'd1) begin
      errors++;
      $display("FAIL glitch_cnt: got %0d/%0d want 1", glitch_cnt, glitch_cnt4);
    end
`endif
    end_read();
  endtask

  task automatic test_saturation();
    clear_live();
    for (int i = 0; i < 17; i++) pulse(4, 4);
    do_read();
    tests++;
    if ({rise_cnt4, sat4} !== {4'd15, 1'b1} || {rise_cnt4, fall_cnt4, sat4} !== exp_snap4()) begin
      errors++;
      $display("FAIL sat_w4: rise=%0d fall=%0d sat=%b want 15 15 1", rise_cnt4, fall_cnt4, sat4);
    end
    tests++;
    if ({rise_cnt, fall_cnt, sat} !== {16'd17, 16'd17, 1'b0}) begin
      errors++;
      $display("FAIL sat_w16: rise=%0d fall=%0d sat=%b want 17 17 0", rise_cnt, fall_cnt, sat);
    end
    end_read();
    clear_live();
    do_read();
    tests++;
    if ({rise_cnt4, fall_cnt4, sat4, rise_cnt, fall_cnt, sat} !== '0) begin
      errors++;
      $display("FAIL sat_clear: w4=%0d/%0d/%b w16=%0d/%0d/%b want all 0",
               rise_cnt4, fall_cnt4, sat4, rise_cnt, fall_cnt, sat);
    end
    end_read();
  endtask

  // A rising transition accepted on the SNAP edge is not in that snapshot;
  // a transition during WAIT is still counted.
  task automatic test_back_to_back();
    int pre;
    pre = m_rise;
    Y_IN = 1'b1;                 // sampled on edge E, accepted on E+3
    repeat (2) @(negedge CLK);
    RD_REQ = 1'b1;               // RUN->SNAP on E+2, SNAP edge is E+3
    repeat (2) @(negedge CLK);
    tests++;
    if ({rd_ack, level} !== 2'b11 || rise_cnt !== 16'(pre) || {rise_cnt, fall_cnt, sat} !== exp_snap16()) begin
      errors++;
      $display("FAIL snap_excludes: ack=%b lvl=%b rise=%0d want 1 1 %0d", rd_ack, level, rise_cnt, pre);
    end
    pulse(0, 6);                 // fall during WAIT
    pulse(6, 6);                 // rise and fall during WAIT
    end_read();
    do_read();
    tests++;
    if (rise_cnt !== 16'(pre + 2) || {rise_cnt, fall_cnt, sat} !== exp_snap16()) begin
      errors++;
      $display("FAIL snap_includes: rise=%0d want %0d", rise_cnt, pre + 2);
    end
    end_read();
  endtask

  task automatic test_clr_snap_idle();
    int pre_r, pre_f;
    pre_r = m_rise;
    pre_f = m_fall;
    RD_REQ = 1'b1;
    @(negedge CLK);              // now in SNAP
    CLR = 1'b1;                  // CLR on the SNAP edge
    @(negedge CLK);
    CLR = 1'b0;
    tests++;
    if ({rise_cnt, fall_cnt} !== {16'(pre_r), 16'(pre_f)} || rd_ack !== 1'b1) begin
      errors++;
      $display("FAIL clr_snap: rise=%0d fall=%0d ack=%b want %0d %0d 1",
               rise_cnt, fall_cnt, rd_ack, pre_r, pre_f);
    end
    end_read();
    do_read();
    tests++;
    if ({rise_cnt, fall_cnt, sat} !== '0) begin
      errors++;
      $display("FAIL clr_after: rise=%0d fall=%0d sat=%b want 0 0 0", rise_cnt, fall_cnt, sat);
    end
    end_read();
    EN = 1'b0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      Y_IN = ~Y_IN;
      repeat (6) @(negedge CLK);
    end
    tests++;
    if (level !== Y_IN) begin
      errors++;
      $display("FAIL idle_tracking: LEVEL=%b want %b", level, Y_IN);
    end
    EN = 1'b1;
    repeat (3) @(negedge CLK);
    do_read();
    tests++;
    if ({rise_cnt, fall_cnt, sat, rise_cnt4, fall_cnt4} !== '0) begin
      errors++;
      $display("FAIL idle_no_count: rise=%0d fall=%0d sat=%b want 0 0 0", rise_cnt, fall_cnt, sat);
    end
    end_read();
  endtask

  task automatic test_random();
    int run;
    for (int r = 0; r < 4; r++) begin
      run = 0;
      for (int c = 0; c < 250; c++) begin
        @(negedge CLK);
        tests++;
        if ({level, level4, rd_ack} !== {m_lvl, m_lvl, m_ack}) begin
          errors++;
          $display("FAIL rand_level r%0d c%0d: lvl=%b/%b ack=%b want %b ack=%b",
                   r, c, level, level4, rd_ack, m_lvl, m_ack);
        end
        if (run == 0) begin
          Y_IN = ~Y_IN;
          run = $urandom_range(1, 7);
        end else begin
          run--;
        end
        EN  = ($urandom_range(0, 9) != 0);
        CLR = ($urandom_range(0, 99) == 0);
      end
      CLR = 1'b0;
      do_read();
      tests++;
      if ({rise_cnt, fall_cnt, sat} !== exp_snap16() || {rise_cnt4, fall_cnt4, sat4} !== exp_snap4()) begin
        errors++;
        $display("FAIL rand_snap r%0d: w16=%h w4=%h want %h %h",
                 r, {rise_cnt, fall_cnt, sat}, {rise_cnt4, fall_cnt4, sat4}, exp_snap16(), exp_snap4());
      end
`ifdef SCS8HD_TOGMON_GLITCH_EN
      tests++;
      if (glitch_cnt !== 8'(cap(m_snap_g, 8))) begin
        errors++;
        $display("FAIL rand_glitch r%0d: got %0d want %0d", r, glitch_cnt, cap(m_snap_g, 8));
      end
`endif
      end_read();
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_glitch();
    test_saturation();
    test_back_to_back();
    test_clr_snap_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
